ir_frame_controller: RTL and testbench
======================================

// Module: ir_frame_controller
// PURPOSE
// - Sequences the IR receive path ahead of the IR key decoder.
// - Synchronises the raw demodulated IR line and times marks/spaces in 1 us ticks.
// - Assembles a 16-bit frame {addr[7:0], cmd[7:0]}, both MSB first, e.g. 16'h0A0B.
// - Presents the frame on ir_code and pulses latch once per valid frame; the decoder
//   captures ir_code on latch. Malformed frames are dropped with an error pulse.
// PARAMETERS
// - TICK_DIV      50     clk cycles per 1 us tick (50 MHz clk)
// - LEAD_MARK_MIN 8000   us, minimum leader mark accepted
// - LEAD_SPC_MIN  4000   us, minimum leader space (data frame)
// - BIT_MARK_MAX  1000   us, maximum data-bit mark
// - ONE_SPC_MIN   1120   us; space >= this is '1', else '0'
// - TIMEOUT_US    12000  us; any mark/space longer than this aborts
// PORTS
// - clk        in   1   system clock
// - reset      in   1   asynchronous, active-high reset
// - ir_rx      in   1   raw IR receiver output, active-low mark, idle high, asynchronous
// - ir_code    out  16  last valid frame {addr,cmd}
// - latch      out  1   one-clk strobe, ir_code valid in the same cycle
// - frame_err  out  1   one-clk strobe on malformed or aborted frame
// - busy       out  1   high while not in IDLE
// BEHAVIOUR
// - Reset values: ir_code=16'h0000, latch=0, frame_err=0, busy=0, FSM=IDLE, counters=0.
// - Reset mid-frame discards the partial frame. No latch or frame_err is issued.
// - ir_rx passes through a 2-FF synchroniser. Edge detect uses the synchronised copy,
//   so input-to-edge latency is 2 clk.
// - Tick counter wraps at TICK_DIV-1.
// - 14-bit duration counter: counts ticks, saturates at 16383, clears on every edge.
// - FSM transitions:
//   - IDLE -> LEAD_MARK on falling edge.
//   - LEAD_MARK -> LEAD_SPC on rising edge if dur >= LEAD_MARK_MIN, else ERR.
//   - LEAD_SPC -> BIT_MARK on falling edge if dur >= LEAD_SPC_MIN, else ERR.
//   - BIT_MARK -> BIT_SPC on rising edge if dur <= BIT_MARK_MAX, else ERR.
//   - BIT_SPC -> BIT_MARK on falling edge. Shift in (dur >= ONE_SPC_MIN) and
//     increment bit_cnt (5 bits).
//   - bit_cnt==16 and the stop mark's rising edge -> DONE.
//   - DONE, 1 clk: ir_code <= shift reg, latch=1 -> IDLE.
//   - ERR, 1 clk: frame_err=1 -> WAIT_IDLE.
//   - WAIT_IDLE -> IDLE once ir_rx has been high for TIMEOUT_US.
// - Timeout: dur > TIMEOUT_US in any state other than IDLE/WAIT_IDLE -> ERR.
// - ir_code holds its value between frames and changes only in the latch cycle.
// - Simultaneous edge and timeout in one cycle: timeout wins.
// CONFIGURATION
// - Macro IR_REPEAT_EN.
// - Defined:
//   - A leader space of 2000..LEAD_SPC_MIN-1 us followed by one stop mark is a repeat.
//   - If a valid frame was latched within the last 110 ms, the repeat re-pulses latch
//     with an unchanged ir_code.
//   - If no valid frame was latched in that window, the repeat pulses frame_err.
//   - Adds a 17-bit ms-tick hold timer, cleared on each latch.
// - Undefined: any leader space < LEAD_SPC_MIN -> ERR (frame_err pulse).
// STRUCTURE
// - Package ir_pkg:
//   - typedef enum logic [2:0] ir_state_t {IDLE, LEAD_MARK, LEAD_SPC, BIT_MARK,
//     BIT_SPC, DONE, ERR, WAIT_IDLE}.
//   - typedef logic [15:0] ir_code_t.
//   - Timing default localparams.
// - Sub-module ir_pulse_timer: synchroniser, edge detect, tick divider and saturating
//   duration counter. Outputs rise, fall, level, dur.
// - The FSM and shift register stay in the top.
// TESTING
// - Frame 16'h0A0B (9000 mark / 4500 space, 560 us marks, 560/1690 spaces, stop mark)
//   -> one latch, ir_code=16'h0A0B, frame_err=0, busy low after stop.
// - Leader mark 3000 us -> frame_err pulse and no latch.
//   - ir_code keeps its previous value.
//   - No new frame is accepted until 12 ms of idle.
// - Line stuck low 13 ms after the 9th bit -> frame_err, busy=1 until 12 ms idle, then 0.
// - Assert reset during bit 7 of 16'h0A12, then send a full 16'h0A04 -> ir_code=16'h0000
//   while reset is held, then one latch with 16'h0A04.
// - IR_REPEAT_EN:
//   - Send 16'h0A06, then a repeat (9000/2250/560) 40 ms later -> second latch,
//     ir_code=16'h0A06.
//   - A repeat after 200 ms idle -> frame_err.
// - Back-to-back frames 16'h0A08 then 16'h0A10, 40 ms apart -> exactly two latches,
//   in order.

Source files
------------

// File: rtl/ir_pkg.sv
// ir_pkg: shared state/code types and default timing for the IR frame controller.
package ir_pkg;
    typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPC, BIT_MARK, BIT_SPC, DONE, ERR, WAIT_IDLE} ir_state_t;
    typedef logic [15:0] ir_code_t;
    localparam int DUR_W = 14;
    localparam int DEF_TICK_DIV = 50;
    localparam int DEF_LEAD_MARK_MIN = 8000;
    localparam int DEF_LEAD_SPC_MIN = 4000;
    localparam int DEF_BIT_MARK_MAX = 1000;
    localparam int DEF_ONE_SPC_MIN = 1120;
    localparam int DEF_TIMEOUT_US = 12000;
    localparam int DEF_REP_SPC_MIN = 2000;
    localparam int DEF_HOLD_MS = 110;
    localparam int DEF_MS_CLKS = 50000;
endpackage

// File: rtl/ir_pulse_timer.sv
// ir_pulse_timer: synchronises ir_rx, detects edges and times the current level in 1 us ticks.
module ir_pulse_timer import ir_pkg::*; #(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ir_rx,
    output logic             rise,
    output logic             fall,
    output logic             level,
    output logic [DUR_W-1:0] dur
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [2:0] sync;
    logic [TW-1:0] tick_cnt;
    logic tick;
    assign level = sync[1];
    assign rise = sync[1] & ~sync[2];
    assign fall = ~sync[1] & sync[2];
    assign tick = tick_cnt == TW'(TICK_DIV - 1);
    // sync[1:0] is the synchroniser; sync[2] is the previous synchronised level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '1;
            tick_cnt <= '0;
            dur <= '0;
        end else begin
            sync <= {sync[1:0], ir_rx};
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            dur <= (rise | fall) ? '0 : (tick && dur != '1) ? dur + 1'b1 : dur;
        end
    end
endmodule

// File: rtl/ir_frame_controller.sv
// ir_frame_controller: decodes {addr,cmd} IR frames from mark/space timing and strobes latch per frame.
// Define IR_REPEAT_EN to accept short-space repeat frames that re-latch the last code.
module ir_frame_controller import ir_pkg::*; #(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int LEAD_MARK_MIN = DEF_LEAD_MARK_MIN,
    parameter int LEAD_SPC_MIN = DEF_LEAD_SPC_MIN,
    parameter int BIT_MARK_MAX = DEF_BIT_MARK_MAX,
    parameter int ONE_SPC_MIN = DEF_ONE_SPC_MIN,
    parameter int TIMEOUT_US = DEF_TIMEOUT_US
`ifdef IR_REPEAT_EN
    ,
    parameter int REP_SPC_MIN = DEF_REP_SPC_MIN,
    parameter int HOLD_MS = DEF_HOLD_MS,
    parameter int MS_CLKS = DEF_MS_CLKS
`endif
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     ir_rx,
    output ir_code_t ir_code,
    output logic     latch,
    output logic     frame_err,
    output logic     busy
);
    localparam logic [DUR_W-1:0] LM = DUR_W'(LEAD_MARK_MIN);
    localparam logic [DUR_W-1:0] LS = DUR_W'(LEAD_SPC_MIN);
    localparam logic [DUR_W-1:0] BM = DUR_W'(BIT_MARK_MAX);
    localparam logic [DUR_W-1:0] OS = DUR_W'(ONE_SPC_MIN);
    localparam logic [DUR_W-1:0] TO = DUR_W'(TIMEOUT_US);
    ir_state_t state, nxt;
    ir_code_t shreg;
    logic [4:0] bit_cnt;
    logic [DUR_W-1:0] dur;
    logic rise, fall, level, rep, short_ok, hold_ok;

    ir_pulse_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk(clk), .reset(reset), .ir_rx(ir_rx),
        .rise(rise), .fall(fall), .level(level), .dur(dur)
    );

    assign latch = state == DONE;
    assign frame_err = state == ERR;
    assign busy = state != IDLE;

`ifdef IR_REPEAT_EN
    localparam logic [DUR_W-1:0] RS = DUR_W'(REP_SPC_MIN);
    logic [16:0] hold;
    logic [31:0] ms_cnt;
    assign short_ok = dur >= RS;
    assign hold_ok = hold < 17'(HOLD_MS);
    // hold resets to all-ones so no repeat is honoured before a first real frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_cnt <= '0;
            hold <= '1;
        end else begin
            ms_cnt <= (ms_cnt == 32'(MS_CLKS - 1)) ? '0 : ms_cnt + 1'b1;
            hold <= latch ? '0 : (ms_cnt == 32'(MS_CLKS - 1) && hold != '1) ? hold + 1'b1 : hold;
        end
    end
`else
    assign short_ok = 1'b0;
    assign hold_ok = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = fall ? LEAD_MARK : IDLE;
            LEAD_MARK: nxt = rise ? (dur >= LM ? LEAD_SPC : ERR) : LEAD_MARK;
            LEAD_SPC:  nxt = fall ? ((dur >= LS || short_ok) ? BIT_MARK : ERR) : LEAD_SPC;
            BIT_MARK:  nxt = !rise ? BIT_MARK : dur > BM ? ERR : rep ? (hold_ok ? DONE : ERR) :
                             bit_cnt == 5'd16 ? DONE : BIT_SPC;
            BIT_SPC:   nxt = fall ? BIT_MARK : BIT_SPC;
            DONE:      nxt = IDLE;
            ERR:       nxt = WAIT_IDLE;
            default:   nxt = (level && !rise && dur >= TO) ? IDLE : WAIT_IDLE;
        endcase
        // a stalled line overrides any edge seen in the same cycle
        if (state inside {LEAD_MARK, LEAD_SPC, BIT_MARK, BIT_SPC} && dur > TO) nxt = ERR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            bit_cnt <= '0;
            rep <= 1'b0;
            ir_code <= '0;
        end else begin
            state <= nxt;
            if (state == LEAD_SPC) bit_cnt <= '0;
            if (state == LEAD_SPC && fall) rep <= dur < LS;
            if (state == BIT_SPC && fall) begin
                shreg <= {shreg[14:0], dur >= OS};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == BIT_MARK && nxt == DONE && !rep) ir_code <= shreg;
        end
    end
endmodule

// File: tb/tb_ir_frame_controller.sv
// tb_ir_frame_controller: directed frames on a 1/20-scaled timebase with 2 clk per tick.
module tb_ir_frame_controller;
    localparam int LM = 450, LS = 225, BM = 28, ZS = 28, OS = 84;
    localparam int BAD = 150, STUCK = 650, IDLE_TO = 650, GAP = 2000, RS = 112, LONG = 10000;
    logic clk = 1'b0, reset = 1'b1, ir_rx = 1'b1;
    logic [15:0] ir_code;
    logic latch, frame_err, busy;
    int checks = 0, errors = 0, latch_cnt = 0, err_cnt = 0;
    logic [15:0] codes [64];

    always #5 clk = ~clk;

    ir_frame_controller #(
        .TICK_DIV(2), .LEAD_MARK_MIN(400), .LEAD_SPC_MIN(200), .BIT_MARK_MAX(50),
        .ONE_SPC_MIN(56), .TIMEOUT_US(600)
`ifdef IR_REPEAT_EN
        , .REP_SPC_MIN(100), .HOLD_MS(110), .MS_CLKS(100)
`endif
    ) dut (
        .clk(clk), .reset(reset), .ir_rx(ir_rx),
        .ir_code(ir_code), .latch(latch), .frame_err(frame_err), .busy(busy)
    );

    always @(negedge clk) begin
        if (latch) begin
            codes[latch_cnt % 64] = ir_code;
            latch_cnt++;
        end
        if (frame_err) err_cnt++;
    end

    task automatic drive(input logic lv, input int t);
        ir_rx = lv;
        repeat (t * 2) @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] c, input int n);
        for (int i = 15; i > 15 - n; i--) begin
            drive(1'b0, BM);
            drive(1'b1, c[i] ? OS : ZS);
        end
    endtask

    task automatic send_frame(input logic [15:0] c);
        drive(1'b0, LM);
        drive(1'b1, LS);
        send_bits(c, 16);
        drive(1'b0, BM);
        drive(1'b1, 20);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        ir_rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ir_code !== 16'h0000) begin errors++; $display("FAIL reset_code got %h want 0000", ir_code); end
        checks++; if (latch !== 1'b0) begin errors++; $display("FAIL reset_latch got %b want 0", latch); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_frame;
        int l0 = latch_cnt, e0 = err_cnt;
        send_frame(16'h0A0B);
        checks++; if (latch_cnt - l0 != 1) begin errors++; $display("FAIL frame_latches got %0d want 1", latch_cnt - l0); end
        checks++; if (codes[l0 % 64] !== 16'h0A0B) begin errors++; $display("FAIL frame_latched_code got %h want 0a0b", codes[l0 % 64]); end
        checks++; if (ir_code !== 16'h0A0B) begin errors++; $display("FAIL frame_code got %h want 0a0b", ir_code); end
        checks++; if (err_cnt != e0) begin errors++; $display("FAIL frame_err got %0d want 0", err_cnt - e0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy got %b want 0", busy); end
    endtask

    task automatic test_bad_leader;
        int l0 = latch_cnt, e0 = err_cnt;
        drive(1'b0, BAD);
        drive(1'b1, 10);
        checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL bad_leader_err got %0d want 1", err_cnt - e0); end
        checks++; if (latch_cnt != l0) begin errors++; $display("FAIL bad_leader_latch got %0d want 0", latch_cnt - l0); end
        checks++; if (ir_code !== 16'h0A0B) begin errors++; $display("FAIL bad_leader_code got %h want 0a0b", ir_code); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bad_leader_busy got %b want 1", busy); end
        send_frame(16'h0A08);
        checks++; if (latch_cnt != l0) begin errors++; $display("FAIL wait_idle_latch got %0d want 0", latch_cnt - l0); end
        checks++; if (ir_code !== 16'h0A0B) begin errors++; $display("FAIL wait_idle_code got %h want 0a0b", ir_code); end
        drive(1'b1, IDLE_TO);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_stuck_low;
        int l0 = latch_cnt, e0 = err_cnt;
        drive(1'b0, LM);
        drive(1'b1, LS);
        send_bits(16'h0A0B, 9);
        drive(1'b0, STUCK);
        checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL stuck_err got %0d want 1", err_cnt - e0); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stuck_busy_low got %b want 1", busy); end
        drive(1'b1, 300);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stuck_busy_partial got %b want 1", busy); end
        drive(1'b1, 350);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stuck_busy_idle got %b want 0", busy); end
        checks++; if (latch_cnt != l0) begin errors++; $display("FAIL stuck_latch got %0d want 0", latch_cnt - l0); end
    endtask

    task automatic test_reset_mid_frame;
        int l0 = latch_cnt, e0 = err_cnt;
        drive(1'b0, LM);
        drive(1'b1, LS);
        send_bits(16'h0A12, 6);
        drive(1'b0, 14);
        reset = 1'b1;
        ir_rx = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (ir_code !== 16'h0000) begin errors++; $display("FAIL midrst_code got %h want 0000", ir_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (latch_cnt != l0 || err_cnt != e0) begin errors++; $display("FAIL midrst_strobes got %0d/%0d want 0/0", latch_cnt - l0, err_cnt - e0); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        send_frame(16'h0A04);
        checks++; if (latch_cnt - l0 != 1) begin errors++; $display("FAIL midrst_latches got %0d want 1", latch_cnt - l0); end
        checks++; if (codes[l0 % 64] !== 16'h0A04) begin errors++; $display("FAIL midrst_latched_code got %h want 0a04", codes[l0 % 64]); end
        checks++; if (ir_code !== 16'h0A04) begin errors++; $display("FAIL midrst_code_after got %h want 0a04", ir_code); end
        checks++; if (err_cnt != e0) begin errors++; $display("FAIL midrst_err got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_back_to_back;
        int l0 = latch_cnt, e0 = err_cnt;
        send_frame(16'h0A08);
        drive(1'b1, GAP);
        send_frame(16'h0A10);
        checks++; if (latch_cnt - l0 != 2) begin errors++; $display("FAIL b2b_latches got %0d want 2", latch_cnt - l0); end
        checks++; if (codes[l0 % 64] !== 16'h0A08) begin errors++; $display("FAIL b2b_first got %h want 0a08", codes[l0 % 64]); end
        checks++; if (codes[(l0 + 1) % 64] !== 16'h0A10) begin errors++; $display("FAIL b2b_second got %h want 0a10", codes[(l0 + 1) % 64]); end
        checks++; if (err_cnt != e0) begin errors++; $display("FAIL b2b_err got %0d want 0", err_cnt - e0); end
    endtask

`ifdef IR_REPEAT_EN
    task automatic send_repeat;
        drive(1'b0, LM);
        drive(1'b1, RS);
        drive(1'b0, BM);
        drive(1'b1, 20);
    endtask

    task automatic test_repeat;
        int l0 = latch_cnt, e0 = err_cnt;
        send_frame(16'h0A06);
        drive(1'b1, GAP);
        send_repeat();
        checks++; if (latch_cnt - l0 != 2) begin errors++; $display("FAIL rep_latches got %0d want 2", latch_cnt - l0); end
        checks++; if (codes[(l0 + 1) % 64] !== 16'h0A06) begin errors++; $display("FAIL rep_code got %h want 0a06", codes[(l0 + 1) % 64]); end
        checks++; if (err_cnt != e0) begin errors++; $display("FAIL rep_err got %0d want 0", err_cnt - e0); end
        drive(1'b1, LONG);
        send_repeat();
        checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL stale_rep_err got %0d want 1", err_cnt - e0); end
        checks++; if (latch_cnt - l0 != 2) begin errors++; $display("FAIL stale_rep_latches got %0d want 2", latch_cnt - l0); end
        checks++; if (ir_code !== 16'h0A06) begin errors++; $display("FAIL stale_rep_code got %h want 0a06", ir_code); end
        drive(1'b1, IDLE_TO);
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_frame();
        test_bad_leader();
        test_stuck_low();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef IR_REPEAT_EN
        test_repeat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
